spi_oled_tx: RTL and testbench

SPI_OLED_TX -- requirements
Module: spi_oled_tx

---
 rtl/spi_oled_tx.sv | 140 ++++++++++++++
 tb/tb_spi_oled_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_oled_tx.sv
// Byte-FIFO-fed SPI mode-0 transmitter for an OLED panel: MSB first, SCK half-period
// of (div_i+1) clocks latched per byte, back-to-back bytes with no idle gap.
module spi_oled_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                div_i,
  input  logic [7:0]                data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      busy_o,
  output logic                      spi_oled_sck_o,
  output logic                      spi_oled_sdo_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            sck_q, sck_d;
  logic            sdo_q, sdo_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      hm1_q, hm1_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            push, pop, half_done, byte_done;

  always_comb begin
    push      = valid_i && ready_q;
    half_done = (cnt_q == hm1_q);
    byte_done = (state_q == SHIFT) && sck_q && half_done && (bit_q == 3'd7);
    pop       = (level_q != '0) && ((state_q == IDLE) || byte_done);

    state_d  = state_q;
    shreg_d  = shreg_q;
    hm1_d    = hm1_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (state_q == SHIFT) begin
      if (half_done) begin
        cnt_d = '0;
        sck_d = ~sck_q;
        // Shift on the falling SCK edge so SDO only moves while SCK is low.
        if (sck_q) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      if (byte_done && !pop) begin
        state_d = IDLE;
        shreg_d = '0;
        sck_d   = 1'b0;
      end
    end

    if (pop) begin
      state_d  = SHIFT;
      shreg_d  = mem_q[rd_ptr_q];
      hm1_d    = div_i;
      cnt_d    = '0;
      bit_d    = '0;
      sck_d    = 1'b0;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    sdo_d   = (state_d == SHIFT) ? shreg_d[7] : 1'b0;
    ready_d = (level_d < LW'(DEPTH));
    busy_d  = (state_d == SHIFT) || (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      sck_q    <= 1'b0;
      sdo_q    <= 1'b0;
      shreg_q  <= '0;
      hm1_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      sck_q    <= sck_d;
      sdo_q    <= sdo_d;
      shreg_q  <= shreg_d;
      hm1_q    <= hm1_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign ready_o        = ready_q;
  assign level_o        = level_q;
  assign busy_o         = busy_q;
  assign spi_oled_sck_o = sck_q;
  assign spi_oled_sdo_o = sdo_q;

endmodule

// File: tb/tb_spi_oled_tx.sv
// Self-checking bench for spi_oled_tx: vector table, directed timing sequences and
// random traffic compared every cycle against a time-based reference model.
module tb_spi_oled_tx;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div = '0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       ready_o, busy_o, sck_o, sdo_o;
  logic [2:0] level_o;

  spi_oled_tx #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .div_i(div), .data_i(data), .valid_i(valid),
    .ready_o(ready_o), .level_o(level_o), .busy_o(busy_o),
    .spi_oled_sck_o(sck_o), .spi_oled_sdo_o(sdo_o)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // Reference model: a byte started at edge s with half-period H occupies 16H cycles;
  // its outputs follow from the elapsed cycle count e alone.
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_e = 0, m_h = 1;
  logic [7:0] m_cur = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  full;
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
    end else begin
      sz   = mq.size();
      full = (sz >= DEPTH);
      if (m_act) begin
        m_e++;
        if (m_e == 16 * m_h) m_act = 1'b0;
      end
      if (!m_act && sz > 0) begin
        m_cur = mq.pop_front();
        m_h   = int'(div) + 1;
        m_e   = 0;
        m_act = 1'b1;
      end
      if (valid && !full) mq.push_back(data);
    end
  endtask

  task automatic model_check();
    logic e_sck, e_sdo, e_rdy, e_busy;
    e_sck  = m_act ? (((m_e / m_h) % 2) == 1) : 1'b0;
    e_sdo  = m_act ? m_cur[7 - m_e / (2 * m_h)] : 1'b0;
    e_rdy  = (mq.size() < DEPTH);
    e_busy = m_act || (mq.size() > 0);
    chk("model", {25'd0, sck_o, sdo_o, ready_o, busy_o, level_o},
                 {25'd0, e_sck, e_sdo, e_rdy, e_busy, 3'(mq.size())});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) model_check();
  endtask

  // Directed-sequence recorder: cycle counter, SCK rise times and sampled bits.
  int   cyc;
  int   busy_drop;
  bit   prev_sck;
  int   rise_c[$];
  bit   rise_b[$];
  logic [7:0] exp_b[$];

  task automatic tick_rec();
    tick();
    cyc++;
    if (sck_o === 1'b1 && !prev_sck) begin
      rise_c.push_back(cyc);
      rise_b.push_back(sdo_o);
    end
    prev_sck = (sck_o === 1'b1);
    if (busy_drop < 0 && cyc > 1 && busy_o === 1'b0) busy_drop = cyc;
  endtask

  task automatic reset_dut();
    rst = 1'b1; valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cyc = 0; busy_drop = -1; prev_sck = 1'b0;
    rise_c.delete(); rise_b.delete(); exp_b.delete();
  endtask

  task automatic chk_bytes(input string nm);
    logic [7:0] g;
    for (int k = 0; k < exp_b.size(); k++) begin
      g = 'x;
      if (rise_b.size() >= 8 * (k + 1))
        for (int j = 0; j < 8; j++) g[7-j] = rise_b[8*k+j];
      chk($sformatf("%s_byte%0d", nm, k), {24'd0, g}, {24'd0, exp_b[k]});
    end
  endtask

  typedef struct {
    logic       rst, valid;
    logic [7:0] data, div;
    logic       sck, sdo, rdy, busy;
    logic [2:0] lvl;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [7:0] dv, input logic s, input logic o,
                              input logic rd, input logic b, input logic [2:0] l);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.div = dv;
    t.sck = s; t.sdo = o; t.rdy = rd; t.busy = b; t.lvl = l;
    return t;
  endfunction

  vec_t tv[21];

  initial begin
    // Byte 0xA0 at H=1, then a push attempted during reset.
    tv[0]  = mk(1, 0, 8'h00, 8'd0, 0, 0, 1, 0, 3'd0);
    tv[1]  = mk(0, 1, 8'hA0, 8'd0, 0, 0, 1, 1, 3'd1);
    tv[2]  = mk(0, 0, 8'h00, 8'd0, 0, 1, 1, 1, 3'd0);
    tv[3]  = mk(0, 0, 8'h00, 8'd0, 1, 1, 1, 1, 3'd0);
    tv[4]  = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[5]  = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[6]  = mk(0, 0, 8'h00, 8'd0, 0, 1, 1, 1, 3'd0);
    tv[7]  = mk(0, 0, 8'h00, 8'd0, 1, 1, 1, 1, 3'd0);
    tv[8]  = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[9]  = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[10] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[11] = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[12] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[13] = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[14] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[15] = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[16] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 1, 3'd0);
    tv[17] = mk(0, 0, 8'h00, 8'd0, 1, 0, 1, 1, 3'd0);
    tv[18] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 3'd0);
    tv[19] = mk(1, 1, 8'hFF, 8'd0, 0, 0, 1, 0, 3'd0);
    tv[20] = mk(0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 3'd0);

    tick(); tick();
    chk_en = 1'b1;

    for (int i = 0; i < 21; i++) begin
      rst = tv[i].rst; valid = tv[i].valid; data = tv[i].data; div = tv[i].div;
      tick();
      chk($sformatf("tbl%0d", i), {27'd0, sck_o, sdo_o, ready_o, busy_o, level_o},
          {27'd0, tv[i].sck, tv[i].sdo, tv[i].rdy, tv[i].busy, tv[i].lvl});
    end

    // Single byte 0xA5, H=2.
    reset_dut();
    div = 8'd1; valid = 1'b1; data = 8'hA5; tick_rec(); valid = 1'b0;
    while (cyc < 40) begin
      tick_rec();
      if (cyc == 2) chk("a5_bit7_at2", {30'd0, sck_o, sdo_o}, {30'd0, 1'b0, 1'b1});
    end
    chk("a5_rises", 32'(rise_c.size()), 32'd8);
    for (int i = 0; i < rise_c.size() && i < 8; i++)
      chk($sformatf("a5_rise%0d", i), 32'(rise_c[i]), 32'(4 + 4 * i));
    exp_b.push_back(8'hA5);
    chk_bytes("a5");
    chk("a5_idle_at", 32'(busy_drop), 32'd34);

    // Back-to-back at H=1.
    reset_dut();
    div = 8'd0; valid = 1'b1; data = 8'h81; tick_rec(); data = 8'h7E; tick_rec(); valid = 1'b0;
    while (cyc < 40) tick_rec();
    chk("b2b_rises", 32'(rise_c.size()), 32'd16);
    if (rise_c.size() >= 16) begin
      chk("b2b_first", 32'(rise_c[0]), 32'd3);
      chk("b2b_span", 32'(rise_c[15] - rise_c[0]), 32'd30);
    end
    exp_b.push_back(8'h81); exp_b.push_back(8'h7E);
    chk_bytes("b2b");

    // Full FIFO at H=256: sixth push dropped.
    reset_dut();
    div = 8'd255;
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; data = 8'((k + 1) * 8'h11);
      tick_rec();
      if (cyc == 5) chk("full_lvl_rdy", {28'd0, ready_o, level_o}, {28'd0, 1'b0, 3'd4});
    end
    valid = 1'b0;
    while (cyc < 20600) tick_rec();
    chk("full_rises", 32'(rise_c.size()), 32'd40);
    for (int k = 0; k < 5; k++) exp_b.push_back(8'((k + 1) * 8'h11));
    chk_bytes("full");

    // div_i change mid-byte.
    reset_dut();
    div = 8'd3; valid = 1'b1; data = 8'h3C; tick_rec(); data = 8'hC3; tick_rec(); valid = 1'b0;
    while (cyc < 100) begin
      tick_rec();
      if (rise_c.size() == 2) div = 8'd0;
    end
    chk("div_rises", 32'(rise_c.size()), 32'd16);
    if (rise_c.size() >= 10) begin
      chk("div_x_first", 32'(rise_c[1] - rise_c[0]), 32'd8);
      chk("div_x_last", 32'(rise_c[7] - rise_c[6]), 32'd8);
      chk("div_y_start", 32'(rise_c[8]), 32'd67);
      chk("div_y_step", 32'(rise_c[9] - rise_c[8]), 32'd2);
    end
    exp_b.push_back(8'h3C); exp_b.push_back(8'hC3);
    chk_bytes("div");

    // Reset during bit 3 with two bytes queued.
    reset_dut();
    div = 8'd1; valid = 1'b1;
    data = 8'h5A; tick_rec(); data = 8'hB1; tick_rec(); data = 8'hC2; tick_rec();
    valid = 1'b0;
    while (cyc < 19) tick_rec();
    chk("rst_lvl_before", 32'(level_o), 32'd2);
    rst = 1'b1; tick_rec(); rst = 1'b0;
    chk("rst_after", {27'd0, sck_o, sdo_o, ready_o, busy_o, level_o},
                     {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
    chk("rst_rises_before", 32'(rise_c.size()), 32'd4);
    while (cyc < 120) tick_rec();
    chk("rst_no_more_rises", 32'(rise_c.size()), 32'd4);

    // Push on the final cycle of a byte with level 2.
    reset_dut();
    div = 8'd0; valid = 1'b1;
    data = 8'h11; tick_rec(); data = 8'h22; tick_rec(); data = 8'h33; tick_rec();
    valid = 1'b0;
    while (cyc < 90) begin
      tick_rec();
      if (cyc == 17) begin
        chk("pp_lvl17", 32'(level_o), 32'd2);
        valid = 1'b1; data = 8'h44;
      end else begin
        valid = 1'b0;
      end
      if (cyc == 18) chk("pp_lvl18", 32'(level_o), 32'd2);
    end
    exp_b.push_back(8'h11); exp_b.push_back(8'h22);
    exp_b.push_back(8'h33); exp_b.push_back(8'h44);
    chk_bytes("pp");

    // Random traffic against the model.
    reset_dut();
    for (int n = 0; n < 4000; n++) begin
      if (n % 150 == 0) div = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 20))
                                                           : 8'($urandom_range(0, 3));
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0; valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
